// File: rtl/dec_counter.sv
// Registered programmable-step down-counter with saturate/wrap selection,
// auto-reload from the last loaded value, terminal-count pulse and sticky underflow.
module dec_counter #(
    parameter int DATAWIDTH = 8,
    parameter int STEPWIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] load_val,
    input  logic                 en,
    input  logic [STEPWIDTH-1:0] step,
    input  logic                 sat,
    input  logic                 auto_reload,
    input  logic                 clr_uf,
    output logic [DATAWIDTH-1:0] q,
    output logic                 zero,
    output logic                 tc,
    output logic                 underflow,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATAWIDTH-1:0] reload;
    logic [DATAWIDTH-1:0] reload_next;
    logic [DATAWIDTH-1:0] q_next;
    logic [DATAWIDTH-1:0] step_ext;
    logic [DATAWIDTH-1:0] res;
    logic [DATAWIDTH:0]   diff;
    logic                 borrow;
    logic                 step_nz;
    logic                 term;
    logic                 dec;
    logic                 fire;
    logic                 tc_next;
    logic                 uf_next;

    // Borrow comes out of the extra top bit of a one-bit-wider subtraction.
    assign step_ext = DATAWIDTH'(step);
    assign diff     = {1'b0, q} - {1'b0, step_ext};
    assign borrow   = diff[DATAWIDTH];
    assign res      = diff[DATAWIDTH-1:0];
    assign step_nz  = (step != '0);
    assign term     = borrow || ((res == '0) && step_nz);
    assign dec      = (state == RUN) && en && !load && step_nz;
    assign fire     = dec && term;

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (load) begin
            state_next = RUN;
        end else if (fire && !auto_reload && sat) begin
            state_next = DONE;
        end
    end

    // Output decode of the state and count registers.
    always_comb begin
        busy = (state == RUN);
        zero = (q == '0);
    end

    // Datapath next values; load overrides any decrement in the same cycle.
    always_comb begin
        q_next      = q;
        reload_next = reload;
        tc_next     = 1'b0;
        uf_next     = clr_uf ? 1'b0 : underflow;
        if (load) begin
            q_next      = load_val;
            reload_next = load_val;
        end else if (dec) begin
            if (!term) begin
                q_next = res;
            end else begin
                tc_next = 1'b1;
                if (borrow) begin
                    uf_next = 1'b1;  // set wins over a coincident clear
                end
                if (auto_reload) begin
                    q_next = reload;
                end else if (sat) begin
                    q_next = '0;
                end else begin
                    q_next = res;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q         <= '0;
            reload    <= '0;
            tc        <= 1'b0;
            underflow <= 1'b0;
        end else begin
            q         <= q_next;
            reload    <= reload_next;
            tc        <= tc_next;
            underflow <= uf_next;
        end
    end

endmodule

// File: doc/dec_counter.md
# dec_counter

Parametrised, registered down-counter for the datapath component library; the sequential successor of the combinational decrement unit. It holds a DATAWIDTH-bit value, subtracts a programmable step on each enabled cycle, and selects saturate-at-zero or modulo wrap-around behaviour. It also supports auto-reload from the last loaded value and reports terminal-count and sticky underflow status. It serves as a loop/iteration counter and timeout unit in scheduled datapaths and their controllers.

## Interface

- DATAWIDTH, 8, width of count value and load value
- STEPWIDTH, 4, width of the step input; STEPWIDTH <= DATAWIDTH
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- load  input  1  load load_val into q and reload register; highest priority
- load_val  input  DATAWIDTH  value to load
- en  input  1  decrement enable, effective only in RUN
- step  input  STEPWIDTH  decrement amount, zero-extended to DATAWIDTH
- sat  input  1  1 = saturate at 0 and stop; 0 = wrap modulo 2^DATAWIDTH
- auto_reload  input  1  1 = on terminal event, reload from reload register
- clr_uf  input  1  clear sticky underflow flag
- q  output  DATAWIDTH  current count (registered)
- zero  output  1  q == 0 (decoded from registered q)
- tc  output  1  terminal-count pulse, registered, one cycle wide
- underflow  output  1  sticky borrow flag (registered)
- busy  output  1  state == RUN

## Operation

- States: IDLE (after reset), RUN (counting), DONE (saturated stop).
- Arithmetic: diff = {1'b0,q} - {1'b0,zext(step)} in DATAWIDTH+1 bits; borrow = diff[DATAWIDTH]; res = diff[DATAWIDTH-1:0].
- Terminal event: borrow, or (res == 0 and step != 0).
- Any state, load=1: q <= load_val, reload <= load_val, state -> RUN, tc <= 0. Otherwise en is ignored in this cycle.
- IDLE/DONE with load=0: q holds, en ignored, tc <= 0.
- RUN, en=0 or step=0: q holds, tc <= 0, no event.
- RUN, en=1, no terminal event: q <= res.
- RUN, en=1, terminal event: tc <= 1; underflow <= 1 if borrow. Next q is selected as follows:
  - auto_reload=1: q <= reload; stay RUN (auto_reload has priority over sat).
  - else sat=1: q <= 0; state -> DONE.
  - else: q <= res (wrapped); stay RUN.
- underflow: set by borrow and cleared by clr_uf. When set and clear occur in the same cycle, set wins.
- load does not clear underflow.

## Timing

- Reset: asynchronous. q=0, reload=0, tc=0, underflow=0, state=IDLE; therefore zero=1 and busy=0. Outputs change immediately on Rst, independent of Clk.
- Reset asserted mid-count aborts the count. After release, the block stays in IDLE until load.
- Latency: load or decrement is visible on q one cycle after the sampling edge. tc and underflow update on the same edge as q.
- tc is high for exactly one cycle per terminal event. Back-to-back events (e.g. wrap every cycle) give tc held high.
- zero and busy are combinational decodes of registers, glitch-free relative to Clk.
- A load coincident with a terminal event: the load wins, with no tc and no underflow set.

## Test plan

- Reset mid-run (DATAWIDTH=8, STEPWIDTH=4): load 10, en=1, step=1; after 3 decrements (q=7) assert Rst between edges -> q=0, zero=1, busy=0, tc=0 immediately. After release with en=1 and no load -> q stays 0.
- Saturate: load 5, step=2, sat=1, auto_reload=0, en held -> q 5,3,1,0. tc=1 on the edge to 0, underflow=1, busy=0 (DONE). Further en -> q stays 0, tc=0.
- Wrap: load 3, step=4, sat=0 -> q=255, tc=1, underflow=1, busy=1. Next edge -> q=251, tc=0, underflow still 1.
- Auto-reload: load 4, step=2, auto_reload=1 -> q 4,2,4,2,4. tc pulses on each return to 4, underflow stays 0 (exact zero, no borrow).
- Priority and collision: underflow=1 with clr_uf=1 on the same edge as a new borrow -> underflow=1. Then clr_uf alone -> 0. load=1 (load_val=0x80) with en=1, q=1, step=3 -> q=0x80, tc=0, underflow unchanged.
- step=0 in RUN with en=1 and q=0 -> q holds 0, tc=0, underflow=0, busy=1.
